tcm_axis_pattern_src: RTL and testbench
=======================================

// Module: tcm_axis_pattern_src
// PURPOSE
//  AXI-Stream master that generates bursts of test data and drives the s_axis_* slave port of the TCM test IP.
//  Produces incrementing, LFSR or constant words, framed into bursts with tlast, with programmable inter-burst gaps.
//  Runs on the stream clock domain; control inputs come from local registers in the same domain.
// PARAMETERS
//  C_M_AXIS_TDATA_WIDTH  32  stream data width in bits (multiple of 8, max 32)
//  C_LEN_WIDTH           16  width of burst_len, num_bursts and the beat counters
//  C_GAP_WIDTH            8  width of gap_cycles
// PORTS
//  m_axis_aclk     in   1      stream clock; all logic on its rising edge
//  m_axis_aresetn  in   1      asynchronous active-low reset
//  start           in   1      1-cycle pulse; starts a run (sampled only in IDLE)
//  stop            in   1      level; ends the run after the current burst
//  mode            in   2      0 incrementing, 1 LFSR, 2 constant(seed), 3 treated as 0
//  seed            in   32     first data word / LFSR seed
//  burst_len       in   C_LEN_WIDTH  beats per burst; 0 treated as 1
//  num_bursts      in   C_LEN_WIDTH  bursts per run; 0 = run ends with no beats
//  gap_cycles      in   C_GAP_WIDTH  idle cycles between bursts
//  busy            out  1      high from the LOAD state through the SEND and GAP states
//  done            out  1      1-cycle pulse at end of run
//  beat_count      out  32     accepted beats since last start (wraps at 2^32)
//  m_axis_tvalid   out  1      stream valid
//  m_axis_tready   in   1      stream ready
//  m_axis_tdata    out  C_M_AXIS_TDATA_WIDTH  stream data
//  m_axis_tstrb    out  C_M_AXIS_TDATA_WIDTH/8  all ones whenever tvalid is high
//  m_axis_tlast    out  1      high on the last beat of each burst
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE. Reset asserted mid-run drops tvalid at once; no resume.
//  States: IDLE -start-> LOAD -> SEND. In LOAD: latch mode, seed, burst_len, num_bursts and gap; clear beat_count.
//   SEND -last-beat handshake-> GAP if gap>0, else straight to the next burst in SEND.
//   GAP -gap cycles elapsed-> SEND. Run end -> DONE -> IDLE.
//  Latency: start at cycle N gives LOAD at N+1 and tvalid=1 at N+2 with data=seed.
//  Handshake: beat transfers when tvalid&tready. Once tvalid is high, tdata, tlast and tvalid are held until transfer.
//   tready is never combinationally looped to tvalid.
//  Back-to-back: with tready=1 and gap=0, one beat per cycle across burst boundaries; no bubble.
//  Gap: tvalid low for exactly gap_cycles cycles after the tlast transfer.
//  Data: mode 0: seed+k mod 2^W for global beat k, continuing across bursts.
//   Mode 1: Galois LFSR, polynomial x^32+x^22+x^2+x+1, advances per transfer; seed 0 is replaced by 1.
//   Mode 2: seed every beat. Data is truncated to C_M_AXIS_TDATA_WIDTH LSBs.
//  tlast: set on beat index burst_len-1 of each burst; with burst_len<=1, tlast is set on every beat.
//  Run end: tlast transfer of burst num_bursts, or the first tlast transfer with stop=1 (also when stop rises mid-burst).
//   stop seen in GAP ends the run at once; num_bursts=0 gives LOAD->DONE with no beats.
//  done: high for the DONE cycle only. busy drops in that same cycle.
//  start is ignored while busy; config inputs are ignored outside LOAD.
//  Counters: beat index and burst index wrap-free within C_LEN_WIDTH range.
// STRUCTURE
//  Shared package tcm_axis_pkg: state encoding (IDLE, LOAD, SEND, GAP, DONE), MODE_* constants, LFSR tap mask 32'h80200003.
//  One sub-module: tcm_lfsr32 (load, advance, seed -> value).
//  Everything else lives in this module: FSM, counters and output register stage.
// TESTING
//  mode0 seed=0x10, len=4, bursts=2, gap=0, tready=1 -> 8 beats 0x10..0x17 on consecutive cycles; tlast on beats 3,7; done 1 cycle after the last beat.
//  Same run with tready toggling 1,0,1,0 -> tdata/tlast held while stalled; beat_count=8.
//  len=3, bursts=3, gap=5 -> exactly 5 cycles with tvalid=0 between bursts; tvalid rises at start+2.
//  mode1 seed=0 -> first beat 0x00000001; following beats match the reference LFSR model for 16 beats.
//  stop raised on beat 1 of burst 1 (len=4, bursts=10) -> run ends after beat 3 of burst 1; done pulses; total 8 beats.
//  Reset pulse mid-burst with tvalid=1, tready=0 -> tvalid/busy 0 immediately; start after release restarts from seed.

Source files
------------

// File: rtl/tcm_axis_pkg.sv
// Shared definitions for the TCM AXI-Stream pattern source: FSM state encoding,
// data mode codes and the Galois LFSR step for x^32+x^22+x^2+x+1.
package tcm_axis_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    // Right-shifting Galois form: the bit shifted out folds the tap mask back in.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/tcm_lfsr32.sv
// 32-bit Galois LFSR. load takes priority over advance; a zero seed becomes 1
// so the register never locks up in the all-zero state.
module tcm_lfsr32
    import tcm_axis_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] seed,
    output logic [31:0] value,
    output logic [31:0] next_value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 32'h0;
        end else if (load) begin
            value <= (seed == 32'h0) ? 32'h1 : seed;
        end else if (advance) begin
            value <= lfsr_step(value);
        end
    end

    assign next_value = lfsr_step(value);

endmodule

// File: rtl/tcm_axis_pattern_src.sv
// AXI-Stream master producing bursts of incrementing, LFSR or constant words,
// framed with tlast and separated by a programmable number of idle cycles.
module tcm_axis_pattern_src
    import tcm_axis_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_LEN_WIDTH          = 16,
    parameter int C_GAP_WIDTH          = 8
) (
    input  logic                                m_axis_aclk,
    input  logic                                m_axis_aresetn,
    input  logic                                start,
    input  logic                                stop,
    input  logic [1:0]                          mode,
    input  logic [31:0]                         seed,
    input  logic [C_LEN_WIDTH-1:0]              burst_len,
    input  logic [C_LEN_WIDTH-1:0]              num_bursts,
    input  logic [C_GAP_WIDTH-1:0]              gap_cycles,
    output logic                                busy,
    output logic                                done,
    output logic [31:0]                         beat_count,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic                                m_axis_tlast
);

    localparam int W  = C_M_AXIS_TDATA_WIDTH;
    localparam int LW = C_LEN_WIDTH;
    localparam int GW = C_GAP_WIDTH;
    localparam logic [LW-1:0] LEN_ONE = 1;
    localparam logic [GW-1:0] GAP_ONE = 1;

    state_t          state, state_next;
    logic [1:0]      mode_r;
    logic [31:0]     seed_r;
    logic [LW-1:0]   len_r, nb_r, beat_idx, burst_idx;
    logic [GW-1:0]   gap_r, gap_cnt;
    logic [31:0]     inc_r, beat_cnt_r;
    logic            tvalid_r, tlast_r, stop_pend;
    logic [W-1:0]    tdata_r;
    logic [31:0]     lfsr_value, lfsr_next;

    logic            xfer, run_end, gap_end;
    logic [1:0]      mode_norm;
    logic [LW-1:0]   len_eff;
    logic [31:0]     first_word, next_word, cur_word;

    tcm_lfsr32 u_lfsr (
        .clk        (m_axis_aclk),
        .rst_n      (m_axis_aresetn),
        .load       (state == ST_LOAD),
        .advance    (xfer),
        .seed       (seed),
        .value      (lfsr_value),
        .next_value (lfsr_next)
    );

    assign mode_norm  = (mode == MODE_LFSR || mode == MODE_CONST) ? mode : MODE_INC;
    assign len_eff    = (burst_len == '0) ? LEN_ONE : burst_len;
    assign first_word = (mode_norm == MODE_LFSR && seed == 32'h0) ? 32'h1 : seed;
    assign xfer       = tvalid_r & m_axis_tready;
    // stop_pend remembers a stop that rose and fell earlier in the burst.
    assign run_end    = (burst_idx == nb_r - LEN_ONE) | stop | stop_pend;
    assign gap_end    = (gap_cnt == gap_r - GAP_ONE);

    // cur_word is the pending beat's value; next_word is the one after a transfer.
    always_comb begin
        cur_word  = inc_r;
        next_word = inc_r + 32'd1;
        case (mode_r)
            MODE_LFSR: begin
                cur_word  = lfsr_value;
                next_word = lfsr_next;
            end
            MODE_CONST: begin
                cur_word  = seed_r;
                next_word = seed_r;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_LOAD;
            ST_LOAD: state_next = (num_bursts == '0) ? ST_DONE : ST_SEND;
            ST_SEND: begin
                if (xfer && tlast_r) begin
                    if (run_end)          state_next = ST_DONE;
                    else if (gap_r != '0) state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (stop)         state_next = ST_DONE;
                else if (gap_end) state_next = ST_SEND;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) state <= ST_IDLE;
        else                 state <= state_next;
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            mode_r     <= MODE_INC;
            seed_r     <= '0;
            len_r      <= '0;
            nb_r       <= '0;
            gap_r      <= '0;
            beat_idx   <= '0;
            burst_idx  <= '0;
            gap_cnt    <= '0;
            inc_r      <= '0;
            beat_cnt_r <= '0;
            tvalid_r   <= 1'b0;
            tlast_r    <= 1'b0;
            tdata_r    <= '0;
            stop_pend  <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    mode_r     <= mode_norm;
                    seed_r     <= seed;
                    len_r      <= len_eff;
                    nb_r       <= num_bursts;
                    gap_r      <= gap_cycles;
                    beat_idx   <= '0;
                    burst_idx  <= '0;
                    gap_cnt    <= '0;
                    inc_r      <= seed;
                    beat_cnt_r <= '0;
                    stop_pend  <= 1'b0;
                    if (num_bursts != '0) begin
                        tvalid_r <= 1'b1;
                        tdata_r  <= first_word[W-1:0];
                        tlast_r  <= (len_eff == LEN_ONE);
                    end
                end
                ST_SEND: begin
                    if (stop) stop_pend <= 1'b1;
                    if (xfer) begin
                        beat_cnt_r <= beat_cnt_r + 32'd1;
                        inc_r      <= inc_r + 32'd1;
                        if (tlast_r) begin
                            beat_idx  <= '0;
                            burst_idx <= burst_idx + LEN_ONE;
                            gap_cnt   <= '0;
                            if (run_end || gap_r != '0) begin
                                tvalid_r <= 1'b0;
                                tlast_r  <= 1'b0;
                            end else begin
                                tdata_r <= next_word[W-1:0];
                                tlast_r <= (len_r == LEN_ONE);
                            end
                        end else begin
                            beat_idx <= beat_idx + LEN_ONE;
                            tdata_r  <= next_word[W-1:0];
                            tlast_r  <= (beat_idx + LEN_ONE == len_r - LEN_ONE);
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + GAP_ONE;
                    if (!stop && gap_end) begin
                        tvalid_r <= 1'b1;
                        tdata_r  <= cur_word[W-1:0];
                        tlast_r  <= (len_r == LEN_ONE);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state == ST_LOAD) || (state == ST_SEND) || (state == ST_GAP);
    assign done          = (state == ST_DONE);
    assign beat_count    = beat_cnt_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tstrb  = {(W/8){tvalid_r}};

endmodule

// File: tb/tb_tcm_axis_pattern_src.sv
// Bench for tcm_axis_pattern_src: directed and random runs scored against a
// beat-list model built from the burst/mode rules, plus timing and reset checks.
module tb_tcm_axis_pattern_src;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = '0;
    logic [31:0] seed = '0;
    logic [15:0] burst_len = '0;
    logic [15:0] num_bursts = '0;
    logic [7:0]  gap_cycles = '0;
    logic        busy, done;
    logic [31:0] beat_count;
    logic        tvalid;
    logic        tready = 1'b0;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;

    tcm_axis_pattern_src #(
        .C_M_AXIS_TDATA_WIDTH (32),
        .C_LEN_WIDTH          (16),
        .C_GAP_WIDTH          (8)
    ) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .start          (start),
        .stop           (stop),
        .mode           (mode),
        .seed           (seed),
        .burst_len      (burst_len),
        .num_bursts     (num_bursts),
        .gap_cycles     (gap_cycles),
        .busy           (busy),
        .done           (done),
        .beat_count     (beat_count),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tdata   (tdata),
        .m_axis_tstrb   (tstrb),
        .m_axis_tlast   (tlast)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    int          n_exp, n_bursts_exp;
    int          rmode;
    int          mon_xfers, first_valid_cyc, first_xfer_cyc, last_xfer_cyc;
    int          done_cyc, done_cnt;
    bit          stall_prev, gap_cnting;
    logic [31:0] held_data;
    logic        held_last;
    int          gap_run;
    int          gaps_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Polynomial x^32+x^22+x^2+x+1: terms x^22, x^2, x^1, x^0 and the x^32 feedback into bit 31.
    function automatic logic [31:0] lfsr_ref(input logic [31:0] v);
        logic [31:0] poly;
        poly = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1;
        return v[0] ? ((v >> 1) ^ poly) : (v >> 1);
    endfunction

    task automatic build_expected(input int md, input logic [31:0] sd, input int len,
                                  input int nb, input int stop_at);
        int          l, nbs;
        logic [31:0] lf, d;
        l   = (len == 0) ? 1 : len;
        nbs = nb;
        if (stop_at >= 0 && (stop_at / l + 1) < nb) nbs = stop_at / l + 1;
        exp_q.delete();
        exp_last_q.delete();
        lf = (sd == 0) ? 32'h1 : sd;
        for (int k = 0; k < nbs * l; k++) begin
            case (md)
                1: begin d = lf; lf = lfsr_ref(lf); end
                2: d = sd;
                default: d = sd + k;
            endcase
            exp_q.push_back(d);
            exp_last_q.push_back((k % l) == l - 1);
        end
        n_exp        = nbs * l;
        n_bursts_exp = nbs;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_ready();
        case (rmode)
            0: tready = 1'b1;
            1: tready = ~tready;
            2: tready = 1'($urandom_range(0, 1));
            default: tready = 1'b0;
        endcase
    endtask

    // Monitor, called once per cycle at the falling edge.
    task automatic sample();
        logic [31:0] ed;
        logic        el;
        if (stall_prev) begin
            check_eq("hold_tvalid", 32'(tvalid), 32'h1);
            check_eq("hold_tdata", tdata, held_data);
            check_eq("hold_tlast", 32'(tlast), 32'(held_last));
        end
        stall_prev = tvalid && !tready;
        held_data  = tdata;
        held_last  = tlast;
        if (gap_cnting) begin
            if (tvalid) begin
                gaps_q.push_back(gap_run);
                gap_cnting = 0;
            end else if (busy) begin
                gap_run++;
            end else begin
                gap_cnting = 0;
            end
        end
        if (tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (tvalid) check_eq("tstrb", 32'(tstrb), 32'hf);
        if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_beat", mon_xfers + 1, n_exp);
            end else begin
                ed = exp_q.pop_front();
                el = exp_last_q.pop_front();
                check_eq($sformatf("tdata[%0d]", mon_xfers), tdata, ed);
                check_eq($sformatf("tlast[%0d]", mon_xfers), 32'(tlast), 32'(el));
            end
            mon_xfers++;
            if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            if (tlast) begin
                gap_cnting = 1;
                gap_run    = 0;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check_eq("busy_at_done", 32'(busy), 32'h0);
        end
    endtask

    task automatic run_test(input string name, input int md, input logic [31:0] sd,
                            input int len, input int nb, input int gap, input int rm,
                            input int stop_at);
        int start_cyc, post, span;
        build_expected(md, sd, len, nb, stop_at);
        mode = 2'(md); seed = sd; burst_len = 16'(len); num_bursts = 16'(nb);
        gap_cycles = 8'(gap); rmode = rm;
        mon_xfers = 0; first_valid_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
        done_cyc = -1; done_cnt = 0; stall_prev = 0; gap_cnting = 0; gaps_q.delete();
        post = 0;
        tready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        drive_ready();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            sample();
            if (done_cnt > 0) begin
                post++;
                if (post >= 3) break;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (stop_at >= 0 && mon_xfers > stop_at) stop = 1'b1;
            drive_ready();
        end
        start = 1'b0;
        stop  = 1'b0;
        check_eq({name, "/done_count"}, done_cnt, 1);
        check_eq({name, "/missing_beats"}, exp_q.size(), 0);
        check_eq({name, "/beat_total"}, mon_xfers, n_exp);
        check_eq({name, "/beat_count"}, beat_count, n_exp);
        if (n_exp > 0) begin
            check_eq({name, "/tvalid_latency"}, first_valid_cyc - start_cyc, 2);
            check_eq({name, "/done_after_last"}, done_cyc - last_xfer_cyc, 1);
            if (rm == 0) begin
                span = n_exp - 1 + gap * (n_bursts_exp - 1);
                check_eq({name, "/xfer_span"}, last_xfer_cyc - first_xfer_cyc, span);
            end
            check_eq({name, "/gap_count"}, gaps_q.size(), n_bursts_exp - 1);
            foreach (gaps_q[g]) check_eq($sformatf("%s/gap[%0d]", name, g), gaps_q[g], gap);
        end else begin
            check_eq({name, "/empty_done_latency"}, done_cyc - start_cyc, 2);
        end
    endtask

    task automatic reset_mid_burst();
        mode = 2'd0; seed = 32'h40; burst_len = 16'd8; num_bursts = 16'd2; gap_cycles = 8'd0;
        tready = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_pre_tvalid", 32'(tvalid), 32'h1);
        check_eq("rst_pre_tdata", tdata, 32'h40);
        check_eq("rst_pre_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_tvalid", 32'(tvalid), 32'h0);
        check_eq("rst_mid_busy", 32'(busy), 32'h0);
        check_eq("rst_mid_tlast", 32'(tlast), 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        run_test("after_reset", 0, 32'h40, 3, 1, 0, 0, -1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int md, len, nb, gap, s, l;
        logic [31:0] sd;
        rmode = 0;
        repeat (2) @(negedge clk);
        check_eq("reset_tvalid", 32'(tvalid), 32'h0);
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_done", 32'(done), 32'h0);
        check_eq("reset_beat_count", beat_count, 32'h0);
        check_eq("reset_tdata", tdata, 32'h0);
        check_eq("reset_tlast", 32'(tlast), 32'h0);
        check_eq("reset_tstrb", 32'(tstrb), 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;

        run_test("inc_b2b",    0, 32'h10, 4, 2, 0, 0, -1);
        run_test("inc_toggle", 0, 32'h10, 4, 2, 0, 1, -1);
        run_test("gap5",       0, $urandom, 3, 3, 5, 0, -1);
        run_test("lfsr_seed0", 1, 32'h0, 8, 2, 1, 2, -1);
        run_test("stop_mid",   2, 32'ha5a5_5a5a, 4, 10, 2, 0, 5);
        run_test("no_bursts",  0, 32'h77, 4, 0, 3, 0, -1);
        run_test("len0_mode3", 3, 32'hffff_fffe, 0, 3, 0, 2, -1);
        reset_mid_burst();

        for (int r = 0; r < 12; r++) begin
            md  = $urandom_range(0, 3);
            sd  = $urandom;
            len = $urandom_range(0, 5);
            nb  = $urandom_range(0, 4);
            gap = $urandom_range(0, 3);
            l   = (len == 0) ? 1 : len;
            s   = -1;
            if (l > 1 && nb > 0 && $urandom_range(0, 2) == 0) begin
                s = $urandom_range(0, nb * l - 1);
                if (s % l == l - 1) s--;
            end
            run_test($sformatf("rand%0d", r), md, sd, len, nb, gap, 2, s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
